// File: rtl/wb_counter_pkg.sv
// Shared register map, bit indices and handshake state type for the Wishbone counter peripheral.
// The optional prescaler (macro WB_COUNTER_PRESCALE_EN) uses OFF_PRESCALE.
package wb_counter_pkg;

   localparam logic [11:0] OFF_CTRL     = 12'h000;
   localparam logic [11:0] OFF_COUNT    = 12'h004;
   localparam logic [11:0] OFF_COMPARE  = 12'h008;
   localparam logic [11:0] OFF_STATUS   = 12'h00C;
   localparam logic [11:0] OFF_PRESCALE = 12'h010;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_DOWN   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_RELOAD = 3;
   localparam int CTRL_OE     = 4;

   localparam int STAT_MATCH = 0;
   localparam int STAT_WRAP  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } wb_state_e;

   // Replace the bytes of old_val selected by sel with the matching bytes of new_val.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone classic slave front end: window decode, IDLE/WAIT/ACK handshake with programmable
// wait states, request latching, and one-cycle write/read strobes aligned with the ack.
module wb_slave_if
   import wb_counter_pkg::*;
#(
   parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
   parameter int          ACK_DELAY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cyc,
   input  logic        i_stb,
   input  logic        i_we,
   input  logic [3:0]  i_sel,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_dat,
   output logic        o_ack,
   output logic        o_wr_en,
   output logic        o_rd_en,
   output logic [11:0] o_off,
   output logic [31:0] o_dat,
   output logic [3:0]  o_sel
);

   localparam logic [3:0] DLY = 4'(ACK_DELAY);

   wb_state_e   r_state;
   logic [3:0]  r_dly;
   logic        r_ack;
   logic        r_we;
   logic [11:0] r_off;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        w_hit;

   assign w_hit = (i_adr[31:12] == BASE_ADR[31:12]);

   // Handshake FSM; ack is registered and high only in the ACK state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_dly   <= 4'd0;
         r_ack   <= 1'b0;
         r_we    <= 1'b0;
         r_off   <= 12'h000;
         r_dat   <= 32'h0000_0000;
         r_sel   <= 4'h0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ack <= 1'b0;
               if (i_cyc && i_stb && w_hit) begin
                  r_we  <= i_we;
                  r_off <= i_adr[11:0];
                  r_dat <= i_dat;
                  r_sel <= i_sel;
                  r_dly <= DLY;
                  if (DLY == 4'd0) begin
                     r_state <= ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!i_cyc) begin
                  r_state <= IDLE;
                  r_ack   <= 1'b0;
               end else if (r_dly <= 4'd1) begin
                  r_dly   <= 4'd0;
                  r_state <= ACK;
                  r_ack   <= 1'b1;
               end else begin
                  r_dly <= r_dly - 4'd1;
               end
            end
            ACK: begin
               r_state <= IDLE;
               r_ack   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   assign o_ack   = r_ack;
   assign o_wr_en = r_ack & r_we;
   assign o_rd_en = r_ack & ~r_we;
   assign o_off   = r_off;
   assign o_dat   = r_dat;
   assign o_sel   = r_sel;

endmodule

// File: rtl/wb_counter_slave.sv
// Caravel user-area Wishbone counter peripheral: up/down counter with compare, auto-reload,
// sticky W1C status and IRQ. Define WB_COUNTER_PRESCALE_EN to add the PRESCALE register.
module wb_counter_slave
   import wb_counter_pkg::*;
#(
   parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
   parameter int          WIDTH     = 32,
   parameter int          IO_BITS   = 16,
   parameter int          ACK_DELAY = 2
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic [IO_BITS-1:0] io_out,
   output logic [IO_BITS-1:0] io_oeb,
   output logic               irq
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(32'd1);

   logic             w_wr_en, w_rd_en;
   logic [11:0]      w_off;
   logic [31:0]      w_dat;
   logic [3:0]       w_sel;
   logic [4:0]       r_ctrl;
   logic [WIDTH-1:0] r_count, r_compare;
   logic             r_match, r_wrap, r_irq;
   logic [31:0]      w_count32, w_compare32, w_cnt_merge, w_cmp_merge, w_rdata;
   logic [WIDTH-1:0] w_next;
   logic             w_tick, w_step, w_set_match, w_set_wrap;
   logic             w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_status;

   wb_slave_if #(.BASE_ADR(BASE_ADR), .ACK_DELAY(ACK_DELAY)) u_if (
      .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_cyc(wbs_cyc_i), .i_stb(wbs_stb_i),
      .i_we(wbs_we_i), .i_sel(wbs_sel_i), .i_adr(wbs_adr_i), .i_dat(wbs_dat_i),
      .o_ack(wbs_ack_o), .o_wr_en(w_wr_en), .o_rd_en(w_rd_en),
      .o_off(w_off), .o_dat(w_dat), .o_sel(w_sel)
   );

   assign w_wr_ctrl   = w_wr_en && (w_off == OFF_CTRL);
   assign w_wr_count  = w_wr_en && (w_off == OFF_COUNT);
   assign w_wr_cmp    = w_wr_en && (w_off == OFF_COMPARE);
   assign w_wr_status = w_wr_en && (w_off == OFF_STATUS);

`ifdef WB_COUNTER_PRESCALE_EN
   logic [15:0] r_psc, r_psc_cnt;
   logic [31:0] w_psc_merge;
   assign w_psc_merge = byte_merge({16'h0000, r_psc}, w_dat, w_sel);
   assign w_tick      = r_ctrl[CTRL_EN] && (r_psc_cnt >= r_psc);

   // Prescaler divides the tick rate; restarts whenever counting stops or COUNT is written.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_psc     <= 16'h0000;
         r_psc_cnt <= 16'h0000;
      end else begin
         if (w_wr_en && (w_off == OFF_PRESCALE)) begin
            r_psc <= w_psc_merge[15:0];
         end
         if (!r_ctrl[CTRL_EN] || w_wr_count || w_tick) begin
            r_psc_cnt <= 16'h0000;
         end else begin
            r_psc_cnt <= r_psc_cnt + 16'h0001;
         end
      end
   end
`else
   assign w_tick = r_ctrl[CTRL_EN];
`endif

   // A COUNT write in the same cycle suppresses the tick entirely, including its flags.
   assign w_step = w_tick && !w_wr_count;

   // Zero-extended views for bus merges and reads, plus next-count and flag-set logic.
   always_comb begin
      w_count32                = 32'h0000_0000;
      w_compare32              = 32'h0000_0000;
      w_count32[WIDTH-1:0]     = r_count;
      w_compare32[WIDTH-1:0]   = r_compare;
      w_cnt_merge              = byte_merge(w_count32, w_dat, w_sel);
      w_cmp_merge              = byte_merge(w_compare32, w_dat, w_sel);
      w_next                   = r_count;
      w_set_match              = 1'b0;
      w_set_wrap               = 1'b0;
      if (w_step) begin
         w_set_match = (r_count == r_compare);
         if (!r_ctrl[CTRL_DOWN]) begin
            if ((r_count == r_compare) && r_ctrl[CTRL_RELOAD]) begin
               w_next = '0;
            end else begin
               w_next     = r_count + CNT_ONE;
               w_set_wrap = &r_count;
            end
         end else if (r_count == '0) begin
            if (r_ctrl[CTRL_RELOAD]) begin
               w_next = r_compare;
            end else begin
               w_next     = '1;
               w_set_wrap = 1'b1;
            end
         end else begin
            w_next = r_count - CNT_ONE;
         end
      end else begin
         w_next = r_count;
      end
   end

   // Register file, counter, sticky flags (set beats W1C clear) and registered IRQ.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ctrl    <= 5'h00;
         r_count   <= '0;
         r_compare <= '0;
         r_match   <= 1'b0;
         r_wrap    <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_wr_ctrl && w_sel[0]) begin
            r_ctrl <= w_dat[4:0];
         end
         if (w_wr_cmp) begin
            r_compare <= w_cmp_merge[WIDTH-1:0];
         end
         if (w_wr_count) begin
            r_count <= w_cnt_merge[WIDTH-1:0];
         end else begin
            r_count <= w_next;
         end
         r_match <= w_set_match | (r_match & ~(w_wr_status & w_sel[0] & w_dat[STAT_MATCH]));
         r_wrap  <= w_set_wrap  | (r_wrap  & ~(w_wr_status & w_sel[0] & w_dat[STAT_WRAP]));
         r_irq   <= r_ctrl[CTRL_IRQ_EN] & (r_match | r_wrap);
      end
   end

   // Read mux for the latched offset; unmapped offsets read zero.
   always_comb begin
      w_rdata = 32'h0000_0000;
      case (w_off)
         OFF_CTRL:     w_rdata = {27'h0000000, r_ctrl};
         OFF_COUNT:    w_rdata = w_count32;
         OFF_COMPARE:  w_rdata = w_compare32;
         OFF_STATUS:   w_rdata = {30'h00000000, r_wrap, r_match};
`ifdef WB_COUNTER_PRESCALE_EN
         OFF_PRESCALE: w_rdata = {16'h0000, r_psc};
`endif
         default:      w_rdata = 32'h0000_0000;
      endcase
   end

   assign wbs_dat_o = w_rd_en ? w_rdata : 32'h0000_0000;
   assign irq       = r_irq;
   assign io_out    = r_count[IO_BITS-1:0];
   assign io_oeb    = {IO_BITS{~r_ctrl[CTRL_OE]}};

endmodule

// File: tb/tb_wb_counter_slave.sv
// Self-checking bench for wb_counter_slave: cycle-level behavioural model plus directed vectors.
module tb_wb_counter_slave;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat;
   logic        ack, irq;
   logic [31:0] dato;
   logic [15:0] io_out, io_oeb;

   always #5 clk = ~clk;

   wb_counter_slave #(.BASE_ADR(32'h3000_0000), .WIDTH(32), .IO_BITS(16), .ACK_DELAY(2)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dato),
      .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
   );

   localparam logic [31:0] A_CTRL = 32'h3000_0000, A_COUNT = 32'h3000_0004,
                           A_CMP  = 32'h3000_0008, A_STAT  = 32'h3000_000C,
                           A_PSC  = 32'h3000_0010;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int lat;

   // Transfer the bench expects to be acked in the current cycle
   bit          e_ack = 1'b0, e_we = 1'b0;
   logic [11:0] e_off = 12'h000;
   logic [31:0] e_dat = 32'h0;
   logic [3:0]  e_sel = 4'h0;

   // Model state
   logic [4:0]  m_ctrl;
   logic [31:0] m_count, m_compare;
   logic        m_match, m_wrap, m_irq;
   logic [15:0] m_psc;
   int          m_pcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   function automatic logic [31:0] mread(input logic [11:0] off);
      case (off)
         12'h000: return {27'h0, m_ctrl};
         12'h004: return m_count;
         12'h008: return m_compare;
         12'h00C: return {30'h0, m_wrap, m_match};
`ifdef WB_COUNTER_PRESCALE_EN
         12'h010: return {16'h0, m_psc};
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Behavioural model: advance one clock using the previous cycle's state and the expected commit
   always @(posedge clk) begin
      logic [32:0] sum;
      logic [31:0] nxt, wv;
      logic        tick, wcount, wr, smatch, swrap, clr_m, clr_w, en_old;
      if (rst) begin
         m_ctrl = 5'h0; m_count = 32'h0; m_compare = 32'h0;
         m_match = 1'b0; m_wrap = 1'b0; m_irq = 1'b0; m_psc = 16'h0; m_pcnt = 0;
      end else begin
         wr     = e_ack && e_we;
         wcount = wr && (e_off == 12'h004);
         en_old = m_ctrl[0];
`ifdef WB_COUNTER_PRESCALE_EN
         tick = en_old && (m_pcnt == int'(m_psc));
`else
         tick = en_old;
`endif
         nxt = m_count; smatch = 1'b0; swrap = 1'b0; clr_m = 1'b0; clr_w = 1'b0;
         if (tick && !wcount) begin
            smatch = (m_count == m_compare);
            if (!m_ctrl[1]) begin
               if (smatch && m_ctrl[3]) nxt = 32'h0;
               else begin
                  sum = {1'b0, m_count} + 33'd1;
                  nxt = sum[31:0];
                  swrap = sum[32];
               end
            end else if (m_count == 32'h0) begin
               if (m_ctrl[3]) nxt = m_compare;
               else begin nxt = 32'hFFFF_FFFF; swrap = 1'b1; end
            end else begin
               nxt = m_count - 32'd1;
            end
         end
         m_irq = m_ctrl[2] & (m_match | m_wrap);
         if (wr) begin
            wv = mrg(mread(e_off), e_dat, e_sel);
            case (e_off)
               12'h000: m_ctrl = wv[4:0];
               12'h004: nxt = wv;
               12'h008: m_compare = wv;
               12'h00C: begin clr_m = e_sel[0] & e_dat[0]; clr_w = e_sel[0] & e_dat[1]; end
`ifdef WB_COUNTER_PRESCALE_EN
               12'h010: m_psc = wv[15:0];
`endif
               default: ;
            endcase
         end
         m_count = nxt;
         m_match = smatch | (m_match & ~clr_m);
         m_wrap  = swrap  | (m_wrap  & ~clr_w);
         m_pcnt  = (!en_old || wcount || tick) ? 0 : m_pcnt + 1;
      end
   end

   // Compare process: DUT outputs against the model on every cycle after reset
   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", {31'h0, ack}, {31'h0, e_ack});
         check("rdata", dato, (e_ack && !e_we) ? mread(e_off) : 32'h0);
         check("io_out", {16'h0, io_out}, {16'h0, m_count[15:0]});
         check("io_oeb", {16'h0, io_oeb}, {16'h0, {16{~m_ctrl[4]}}});
         check("irq", {31'h0, irq}, {31'h0, m_irq});
      end
   end

   task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; lat = -1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); if (ack && lat < 0) lat = i;
         @(posedge clk); #1;
      end
      e_ack = 1'b1; e_we = w; e_off = a[11:0]; e_dat = d; e_sel = s;
      @(negedge clk); if (ack && lat < 0) lat = 3;
      rd = dato;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; e_ack = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] unused;
      xfer(1'b1, a, d, 4'hF, unused);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      xfer(1'b0, a, 32'h0, 4'hF, v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] r1, r2;
      int n, mx;
      bit seen;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
      @(posedge clk); #1; chk_en = 1'b1;
      @(posedge clk); #1; rst = 1'b0;

      // Reset state
      check("rst_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
      check("rst_irq", {31'h0, irq}, 32'h0);
      rd(A_CTRL, r1); check("rst_ctrl", r1, 32'h0);

      // Free-running up count; two reads spaced by 10 idle cycles are 14 counts apart
      wr(A_CTRL, 32'h1);
      rd(A_COUNT, r1);
      check("ack_latency", lat, 32'd3);
      repeat (10) @(posedge clk); #1;
      rd(A_COUNT, r2);
      check("count_delta", r2 - r1, 32'd14);

      // Compare + auto-reload + IRQ
      wr(A_CTRL, 32'h0); wr(A_COUNT, 32'h0); wr(A_CMP, 32'h5); wr(A_CTRL, 32'h0D);
      mx = 0; seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (int'(io_out) > mx) mx = int'(io_out);
         if (irq) seen = 1'b1;
      end
      @(posedge clk); #1;
      check("reload_max", mx, 32'd5);
      check("irq_seen", {31'h0, seen}, 32'h1);
      rd(A_STAT, r1); check("status_match", r1, 32'h1);
      wr(A_CTRL, 32'h0C); wr(A_STAT, 32'h1);
      repeat (2) @(posedge clk); #1;
      check("irq_cleared", {31'h0, irq}, 32'h0);
      wr(A_CTRL, 32'h0D);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (irq) seen = 1'b1; end
      @(posedge clk); #1;
      check("irq_reassert", {31'h0, seen}, 32'h1);

      // Down count from 0 wraps to all-ones
      wr(A_CTRL, 32'h0); wr(A_STAT, 32'h3); wr(A_COUNT, 32'h0); wr(A_CTRL, 32'h13);
      @(posedge clk); #1;
      check("down_io_out", {16'h0, io_out}, 32'h0000_FFFF);
      check("down_io_oeb", {16'h0, io_oeb}, 32'h0);
      rd(A_STAT, r1); check("status_wrap", r1, 32'h2);

      // Byte-lane write to COUNT while counting: write wins over tick
      wr(A_CTRL, 32'h0); wr(A_COUNT, 32'h1234_5600); wr(A_CTRL, 32'h1);
      xfer(1'b1, A_COUNT, 32'hFFFF_FFAB, 4'b0001, r1);
      rd(A_COUNT, r1); check("byte_write", r1, 32'h1234_56AE);

      // Address outside the window is never acked
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_1000; dat = 32'h1; sel = 4'hF; n = 0;
      repeat (20) begin @(negedge clk); if (ack) n++; end
      @(posedge clk); #1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("miss_acks", n, 32'd0);
      rd(32'h3000_0020, r1); check("unmapped_read", r1, 32'h0);
`ifndef WB_COUNTER_PRESCALE_EN
      rd(A_PSC, r1); check("psc_absent", r1, 32'h0);
`endif

      // Abort during WAIT leaves COMPARE untouched
      wr(A_CTRL, 32'h0);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CMP; dat = 32'h55; sel = 4'hF;
      @(posedge clk); #1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (5) @(posedge clk); #1;
      rd(A_CMP, r1); check("abort_compare", r1, 32'h5);

      // Reset during WAIT: no ack, all registers cleared
      wr(A_CTRL, 32'h17);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_COUNT; dat = 32'h77; sel = 4'hF;
      @(posedge clk); #1; rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      check("rst2_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
      rd(A_CTRL, r1);  check("rst2_ctrl", r1, 32'h0);
      rd(A_COUNT, r1); check("rst2_count", r1, 32'h0);
      rd(A_CMP, r1);   check("rst2_compare", r1, 32'h0);
      rd(A_STAT, r1);  check("rst2_status", r1, 32'h0);

`ifdef WB_COUNTER_PRESCALE_EN
      // One count per four cycles with PRESCALE=3
      wr(A_PSC, 32'h3); wr(A_COUNT, 32'h0); wr(A_CTRL, 32'h1);
      rd(A_COUNT, r1);
      repeat (8) @(posedge clk); #1;
      rd(A_COUNT, r2);
      check("prescale_delta", r2 - r1, 32'd3);
      rd(A_PSC, r1); check("psc_read", r1, 32'h3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
